prom_loader: RTL and testbench

- Parametrised successor to the top-level UART-to-PROM fill logic.
- Assembles a UART byte stream into WORD_BYTES-wide words and issues single-cycle PROM write strobes.
- Two modes:
  - RAW: continuous stream, address wraps.
  - FRAMED: sync byte, length, payload, 8-bit checksum, with done/error status.
- Sits between the UART receiver and the instruction PROM write port; the CPU is held in reset while it runs.

---
 rtl/prom_loader_pkg.sv | 30 +++
 rtl/prom_loader_word_assembler.sv | 61 ++++++
 rtl/prom_loader.sv | 204 ++++++++++++++++++++
 tb/tb_prom_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prom_loader_pkg.sv
// Shared types and constants for the UART-to-PROM loader.
package prom_loader_pkg;

    // Loader FSM states.
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RAW_DATA = 4'd1,
        SYNC     = 4'd2,
        LEN_LO   = 4'd3,
        LEN_HI   = 4'd4,
        DATA     = 4'd5,
        CSUM     = 4'd6,
        DONE     = 4'd7,
        ERROR    = 4'd8
    } state_e;

    // Frame start marker.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // 8-bit modular checksum accumulation.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    // True for states in which a load is still in progress.
    function automatic logic is_busy_state(input state_e s);
        return !((s == IDLE) || (s == DONE) || (s == ERROR));
    endfunction

endpackage

// File: rtl/prom_loader_word_assembler.sv
// Packs a byte stream little-endian into WORD_BYTES-wide words.
// word_complete_o flags (combinationally) that the byte now being accepted
// finishes a word; word_o/word_valid_o present that word one cycle later.
module word_assembler #(
    parameter int WORD_BYTES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear_i,
    input  logic                    byte_valid_i,
    input  logic [7:0]              byte_data_i,
    output logic [8*WORD_BYTES-1:0] word_o,
    output logic                    word_valid_o,
    output logic                    word_complete_o
);

    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    logic [IDX_W-1:0]        idx_r;
    logic [8*WORD_BYTES-1:0] shift_r;
    logic [8*WORD_BYTES-1:0] word_r;
    logic                    valid_r;
    logic [8*WORD_BYTES-1:0] merged_s;

    assign word_complete_o = byte_valid_i & ~clear_i & (idx_r == LAST_IDX);
    assign word_o          = word_r;
    assign word_valid_o    = valid_r;

    // Partial word with the incoming byte dropped into its lane.
    always_comb begin
        merged_s = shift_r;
        merged_s[8*int'(idx_r) +: 8] = byte_data_i;
    end

    // Byte index, partial word and completed-word registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_r   <= '0;
            shift_r <= '0;
            word_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= word_complete_o;
            if (clear_i) begin
                idx_r   <= '0;
                shift_r <= '0;
            end else if (byte_valid_i) begin
                if (idx_r == LAST_IDX) begin
                    word_r  <= merged_s;
                    idx_r   <= '0;
                    shift_r <= '0;
                end else begin
                    shift_r <= merged_s;
                    idx_r   <= idx_r + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/prom_loader.sv
// UART-to-PROM loader: RAW streaming fill or FRAMED fill with length and
// checksum. Words are written one cycle after their last byte arrives.
module prom_loader
    import prom_loader_pkg::*;
#(
    parameter int WORD_BYTES = 2,
    parameter int ROM_WORDS  = 24,
    parameter int ADDR_BITS  = $clog2(ROM_WORDS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable_i,
    input  logic                    mode_framed_i,
    input  logic [7:0]              rx_data_i,
    input  logic                    rx_ready_i,
    output logic                    rx_ack_o,
    output logic                    wr_en_o,
    output logic [ADDR_BITS-1:0]    wr_addr_o,
    output logic [8*WORD_BYTES-1:0] wr_data_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [ADDR_BITS:0]      words_loaded_o
);

    localparam int CNT_W = ADDR_BITS + 1;
    localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(ROM_WORDS - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX   = CNT_W'(ROM_WORDS);
    localparam logic [15:0]          LEN_MAX   = 16'(ROM_WORDS);

    state_e                  state_r;
    state_e                  next_state_s;
    logic [ADDR_BITS-1:0]    addr_r;
    logic [ADDR_BITS-1:0]    wr_addr_r;
    logic [CNT_W-1:0]        words_r;
    logic [7:0]              csum_r;
    logic [7:0]              len_lo_r;
    logic [15:0]             len_r;
    logic [15:0]             len_full_s;
    logic                    busy_r;
    logic                    done_r;
    logic                    error_r;
    logic                    byte_s;
    logic                    feed_s;
    logic                    clear_s;
    logic                    word_done_s;
    logic                    last_word_s;
    logic                    word_valid_s;
    logic [8*WORD_BYTES-1:0] word_s;

    assign byte_s      = rx_ready_i & enable_i;
    assign rx_ack_o    = byte_s;
    assign feed_s      = byte_s & ((state_r == RAW_DATA) || (state_r == DATA));
    assign clear_s     = ~enable_i | (state_r == IDLE);
    assign len_full_s  = {rx_data_i, len_lo_r};
    assign last_word_s = ((17'(words_r) + 17'd1) == {1'b0, len_r});

    word_assembler #(
        .WORD_BYTES (WORD_BYTES)
    ) u_asm (
        .clk             (clk),
        .reset_n         (reset_n),
        .clear_i         (clear_s),
        .byte_valid_i    (feed_s),
        .byte_data_i     (rx_data_i),
        .word_o          (word_s),
        .word_valid_o    (word_valid_s),
        .word_complete_o (word_done_s)
    );

    assign wr_en_o        = word_valid_s;
    assign wr_data_o      = word_s;
    assign wr_addr_o      = wr_addr_r;
    assign busy_o         = busy_r;
    assign done_o         = done_r;
    assign error_o        = error_r;
    assign words_loaded_o = words_r;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; a low enable wins over any arriving byte.
    always_comb begin
        next_state_s = state_r;
        if (!enable_i) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:     next_state_s = mode_framed_i ? SYNC : RAW_DATA;
                RAW_DATA: next_state_s = RAW_DATA;
                SYNC, DONE: begin
                    if (byte_s && (rx_data_i == SYNC_BYTE)) begin
                        next_state_s = LEN_LO;
                    end else begin
                        next_state_s = state_r;
                    end
                end
                LEN_LO: begin
                    if (byte_s) begin
                        next_state_s = LEN_HI;
                    end else begin
                        next_state_s = LEN_LO;
                    end
                end
                LEN_HI: begin
                    if (!byte_s) begin
                        next_state_s = LEN_HI;
                    end else if ((len_full_s == 16'd0) || (len_full_s > LEN_MAX)) begin
                        next_state_s = ERROR;
                    end else begin
                        next_state_s = DATA;
                    end
                end
                DATA: begin
                    if (word_done_s && last_word_s) begin
                        next_state_s = CSUM;
                    end else begin
                        next_state_s = DATA;
                    end
                end
                CSUM: begin
                    if (!byte_s) begin
                        next_state_s = CSUM;
                    end else if (rx_data_i == csum_r) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = ERROR;
                    end
                end
                ERROR:   next_state_s = ERROR;
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Status flags, address, word count, length and checksum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            addr_r    <= '0;
            wr_addr_r <= '0;
            words_r   <= '0;
            csum_r    <= 8'd0;
            len_lo_r  <= 8'd0;
            len_r     <= 16'd0;
        end else begin
            busy_r  <= is_busy_state(next_state_s);
            done_r  <= (next_state_s == DONE);
            error_r <= (next_state_s == ERROR);
            if (!enable_i) begin
                addr_r  <= '0;
                words_r <= '0;
                csum_r  <= 8'd0;
            end else begin
                case (state_r)
                    IDLE: begin
                        addr_r  <= '0;
                        words_r <= '0;
                        csum_r  <= 8'd0;
                    end
                    SYNC, DONE: begin
                        if (byte_s && (rx_data_i == SYNC_BYTE)) begin
                            addr_r  <= '0;
                            words_r <= '0;
                            csum_r  <= 8'd0;
                        end
                    end
                    LEN_LO: begin
                        if (byte_s) begin
                            len_lo_r <= rx_data_i;
                        end
                    end
                    LEN_HI: begin
                        if (byte_s) begin
                            len_r <= len_full_s;
                        end
                    end
                    DATA: begin
                        if (byte_s) begin
                            csum_r <= csum_add(csum_r, rx_data_i);
                        end
                    end
                    default: begin
                        csum_r <= csum_r;
                    end
                endcase
                if (word_done_s) begin
                    wr_addr_r <= addr_r;
                    addr_r    <= (addr_r == ADDR_LAST) ? '0 : addr_r + ADDR_BITS'(1);
                    words_r   <= (words_r == CNT_MAX) ? words_r : words_r + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_prom_loader.sv
module tb_prom_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        enable_a, mode_a, rx_ready_a;
    logic [7:0]  rx_data_a;
    logic        rx_ack_a, wr_en_a, busy_a, done_a, error_a;
    logic [1:0]  wr_addr_a;
    logic [15:0] wr_data_a;
    logic [2:0]  words_a;

    logic        enable_b, mode_b, rx_ready_b;
    logic [7:0]  rx_data_b;
    logic        rx_ack_b, wr_en_b, busy_b, done_b, error_b;
    logic [1:0]  wr_addr_b;
    logic [23:0] wr_data_b;
    logic [2:0]  words_b;

    int compared = 0;
    int mismatched = 0;

    prom_loader #(.WORD_BYTES(2), .ROM_WORDS(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable_i(enable_a), .mode_framed_i(mode_a),
        .rx_data_i(rx_data_a), .rx_ready_i(rx_ready_a), .rx_ack_o(rx_ack_a),
        .wr_en_o(wr_en_a), .wr_addr_o(wr_addr_a), .wr_data_o(wr_data_a),
        .busy_o(busy_a), .done_o(done_a), .error_o(error_a), .words_loaded_o(words_a)
    );

    prom_loader #(.WORD_BYTES(3), .ROM_WORDS(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable_i(enable_b), .mode_framed_i(mode_b),
        .rx_data_i(rx_data_b), .rx_ready_i(rx_ready_b), .rx_ack_o(rx_ack_b),
        .wr_en_o(wr_en_b), .wr_addr_o(wr_addr_b), .wr_data_o(wr_data_b),
        .busy_o(busy_b), .done_o(done_b), .error_o(error_b), .words_loaded_o(words_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Send one byte to DUT A; check the write strobe one cycle later and
    // that it has dropped again the cycle after.
    task automatic send_a(input logic [7:0] b, input bit exp_wr, input int exp_addr, input int exp_data);
        rx_data_a  = b;
        rx_ready_a = 1'b1;
        #1;
        check("rx_ack", 32'(rx_ack_a), 32'(enable_a));
        @(posedge clk); #1;
        rx_ready_a = 1'b0;
        check("wr_en", 32'(wr_en_a), 32'(exp_wr));
        if (exp_wr) begin
            check("wr_addr", 32'(wr_addr_a), exp_addr);
            check("wr_data", 32'(wr_data_a), exp_data);
        end
        @(posedge clk); #1;
        check("wr_en_pulse", 32'(wr_en_a), 32'd0);
    endtask

    task automatic send_b(input logic [7:0] b, input bit exp_wr, input int exp_addr, input int exp_data);
        rx_data_b  = b;
        rx_ready_b = 1'b1;
        @(posedge clk); #1;
        rx_ready_b = 1'b0;
        check("b_wr_en", 32'(wr_en_b), 32'(exp_wr));
        if (exp_wr) begin
            check("b_wr_addr", 32'(wr_addr_b), exp_addr);
            check("b_wr_data", 32'(wr_data_b), exp_data);
        end
        @(posedge clk); #1;
        check("b_wr_en_pulse", 32'(wr_en_b), 32'd0);
    endtask

    // Return DUT A to IDLE, then start it in the requested mode.
    task automatic restart_a(input logic framed);
        enable_a = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy_a), 32'd0);
        check("idle_words", 32'(words_a), 32'd0);
        mode_a   = framed;
        enable_a = 1'b1;
        @(posedge clk); #1;
        check("start_busy", 32'(busy_a), 32'd1);
    endtask

    // Model of a framed load: junk, sync, length, payload, checksum.
    task automatic framed_random(input int len_words, input bit good);
        logic [7:0] payload[];
        int sum;
        int njunk;
        logic [7:0] junk;
        logic [7:0] cbyte;
        payload = new[2*len_words];
        sum = 0;
        njunk = $urandom_range(0, 2);
        for (int i = 0; i < 2*len_words; i++) begin
            payload[i] = 8'($urandom_range(0, 255));
            sum = (sum + int'(payload[i])) % 256;
        end
        for (int j = 0; j < njunk; j++) begin
            junk = 8'($urandom_range(0, 255));
            if (junk == 8'hA5) junk = 8'h00;
            send_a(junk, 1'b0, 0, 0);
        end
        send_a(8'hA5, 1'b0, 0, 0);
        send_a(8'(len_words), 1'b0, 0, 0);
        send_a(8'h00, 1'b0, 0, 0);
        for (int i = 0; i < 2*len_words; i++) begin
            if (i % 2 == 1)
                send_a(payload[i], 1'b1, i/2, (int'(payload[i]) << 8) | int'(payload[i-1]));
            else
                send_a(payload[i], 1'b0, 0, 0);
        end
        cbyte = good ? 8'(sum) : (8'(sum) ^ 8'($urandom_range(1, 255)));
        send_a(cbyte, 1'b0, 0, 0);
        check("rf_done", 32'(done_a), 32'(good));
        check("rf_error", 32'(error_a), 32'(!good));
        check("rf_busy", 32'(busy_a), 32'd0);
        check("rf_words", 32'(words_a), 32'(len_words));
    endtask

    initial begin
        logic [7:0] bytes[];
        int k;
        reset_n = 1'b0;
        enable_a = 1'b0; mode_a = 1'b0; rx_ready_a = 1'b0; rx_data_a = 8'h00;
        enable_b = 1'b0; mode_b = 1'b0; rx_ready_b = 1'b0; rx_data_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", 32'(wr_en_a), 32'd0);
        check("rst_wr_addr", 32'(wr_addr_a), 32'd0);
        check("rst_wr_data", 32'(wr_data_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_error", 32'(error_a), 32'd0);
        check("rst_words", 32'(words_a), 32'd0);
        check("rst_ack", 32'(rx_ack_a), 32'd0);
        reset_n = 1'b1;

        // RAW directed
        restart_a(1'b0);
        send_a(8'h34, 1'b0, 0, 0);
        send_a(8'h12, 1'b1, 0, 32'h1234);
        send_a(8'h78, 1'b0, 0, 0);
        send_a(8'h56, 1'b1, 1, 32'h5678);
        check("raw_done", 32'(done_a), 32'd0);
        check("raw_error", 32'(error_a), 32'd0);
        check("raw_words", 32'(words_a), 32'd2);

        // RAW wrap: five words into four locations
        restart_a(1'b0);
        for (int w = 1; w <= 5; w++) begin
            send_a(8'(w), 1'b0, 0, 0);
            send_a(8'h00, 1'b1, (w-1) % 4, w);
        end
        check("wrap_words", 32'(words_a), 32'd4);
        check("wrap_busy", 32'(busy_a), 32'd1);

        // RAW random
        restart_a(1'b0);
        k = $urandom_range(5, 9);
        bytes = new[2*k];
        for (int i = 0; i < 2*k; i++) bytes[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 2*k; i++) begin
            if (i % 2 == 1)
                send_a(bytes[i], 1'b1, (i/2) % 4, (int'(bytes[i]) << 8) | int'(bytes[i-1]));
            else
                send_a(bytes[i], 1'b0, 0, 0);
        end
        check("rraw_words", 32'(words_a), (k > 4) ? 32'd4 : 32'(k));
        check("rraw_done", 32'(done_a), 32'd0);

        // FRAMED good
        restart_a(1'b1);
        send_a(8'hFF, 1'b0, 0, 0);
        send_a(8'hA5, 1'b0, 0, 0);
        send_a(8'h02, 1'b0, 0, 0);
        send_a(8'h00, 1'b0, 0, 0);
        send_a(8'h11, 1'b0, 0, 0);
        send_a(8'h22, 1'b1, 0, 32'h2211);
        send_a(8'h33, 1'b0, 0, 0);
        send_a(8'h44, 1'b1, 1, 32'h4433);
        check("fg_busy_csum", 32'(busy_a), 32'd1);
        send_a(8'hAA, 1'b0, 0, 0);
        check("fg_done", 32'(done_a), 32'd1);
        check("fg_error", 32'(error_a), 32'd0);
        check("fg_busy", 32'(busy_a), 32'd0);
        send_a(8'h00, 1'b0, 0, 0);
        check("fg_done_hold", 32'(done_a), 32'd1);
        send_a(8'hA5, 1'b0, 0, 0);
        check("fg_done_clr", 32'(done_a), 32'd0);
        check("fg_rebusy", 32'(busy_a), 32'd1);

        // FRAMED bad checksum
        restart_a(1'b1);
        send_a(8'hA5, 1'b0, 0, 0);
        send_a(8'h02, 1'b0, 0, 0);
        send_a(8'h00, 1'b0, 0, 0);
        send_a(8'h11, 1'b0, 0, 0);
        send_a(8'h22, 1'b1, 0, 32'h2211);
        send_a(8'h33, 1'b0, 0, 0);
        send_a(8'h44, 1'b1, 1, 32'h4433);
        send_a(8'hAB, 1'b0, 0, 0);
        check("fb_error", 32'(error_a), 32'd1);
        check("fb_done", 32'(done_a), 32'd0);
        send_a(8'hA5, 1'b0, 0, 0);
        check("fb_error_sticky", 32'(error_a), 32'd1);

        // FRAMED bad lengths
        restart_a(1'b1);
        send_a(8'hA5, 1'b0, 0, 0);
        send_a(8'h05, 1'b0, 0, 0);
        send_a(8'h00, 1'b0, 0, 0);
        check("len5_error", 32'(error_a), 32'd1);
        send_a(8'h11, 1'b0, 0, 0);
        send_a(8'h22, 1'b0, 0, 0);
        check("len5_words", 32'(words_a), 32'd0);
        restart_a(1'b1);
        send_a(8'hA5, 1'b0, 0, 0);
        send_a(8'h00, 1'b0, 0, 0);
        send_a(8'h00, 1'b0, 0, 0);
        check("len0_error", 32'(error_a), 32'd1);
        check("len0_busy", 32'(busy_a), 32'd0);

        // FRAMED random frames
        for (int f = 0; f < 4; f++) begin
            restart_a(1'b1);
            framed_random($urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end

        // enable low in DATA with a partial word pending
        restart_a(1'b1);
        send_a(8'hA5, 1'b0, 0, 0);
        send_a(8'h01, 1'b0, 0, 0);
        send_a(8'h00, 1'b0, 0, 0);
        send_a(8'h11, 1'b0, 0, 0);
        send_a(8'h22, 1'b1, 0, 32'h2211);
        send_a(8'h33, 1'b0, 0, 0);
        check("en_done", 32'(done_a), 32'd1);
        send_a(8'hA5, 1'b0, 0, 0);
        send_a(8'h01, 1'b0, 0, 0);
        send_a(8'h00, 1'b0, 0, 0);
        send_a(8'h44, 1'b0, 0, 0);
        check("en_busy_data", 32'(busy_a), 32'd1);
        check("en_words_data", 32'(words_a), 32'd0);
        restart_a(1'b0);
        check("en_done_clr", 32'(done_a), 32'd0);
        check("en_error_clr", 32'(error_a), 32'd0);
        send_a(8'h78, 1'b0, 0, 0);
        send_a(8'h56, 1'b1, 0, 32'h5678);

        // async reset mid-word
        restart_a(1'b0);
        send_a(8'h11, 1'b0, 0, 0);
        send_a(8'h22, 1'b1, 0, 32'h2211);
        send_a(8'h34, 1'b0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_wr_en", 32'(wr_en_a), 32'd0);
        check("ar_wr_data", 32'(wr_data_a), 32'd0);
        check("ar_busy", 32'(busy_a), 32'd0);
        check("ar_words", 32'(words_a), 32'd0);
        rx_ready_a = 1'b1;
        #1;
        check("ar_ack_hi", 32'(rx_ack_a), 32'd1);
        rx_ready_a = 1'b0;
        #1;
        check("ar_ack_lo", 32'(rx_ack_a), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("ar_restart_busy", 32'(busy_a), 32'd1);
        send_a(8'h78, 1'b0, 0, 0);
        send_a(8'h56, 1'b1, 0, 32'h5678);

        // three-byte words
        enable_b = 1'b1;
        @(posedge clk); #1;
        send_b(8'h01, 1'b0, 0, 0);
        send_b(8'h02, 1'b0, 0, 0);
        send_b(8'h03, 1'b1, 0, 32'h030201);
        check("b_words", 32'(words_b), 32'd1);
        check("b_done", 32'(done_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
